// File: rtl/shift_sub_divider.sv
// shift_sub_divider: restoring shift-and-subtract divider,
// one quotient bit per clock behind a start/done handshake.
module shift_sub_divider #(
    parameter int DW = 6,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DW-1:0] r_q;
    logic [VW-1:0] r_d;
    logic [VW-1:0] r_r;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dbz;
    logic          r_busy;
    logic          r_done;

    logic [VW:0]   w_rs;
    logic [VW:0]   w_t;
    logic [VW-1:0] w_r_nxt;
    logic [DW-1:0] w_q_nxt;
    logic          w_last;
    logic          w_zero;

    // Trial subtract is one bit wider than R so the borrow lands in w_t[VW].
    assign w_rs    = {r_r, r_q[DW-1]};
    assign w_t     = w_rs - {1'b0, r_d};
    assign w_r_nxt = w_t[VW] ? w_rs[VW-1:0] : w_t[VW-1:0];
    assign w_q_nxt = {r_q[DW-2:0], ~w_t[VW]};
    assign w_last  = (r_cnt == LAST);
    assign w_zero  = (r_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_zero || w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_zero) begin
                        r_quot <= '1;
                        r_rem  <= '0;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_q   <= w_q_nxt;
                        r_r   <= w_r_nxt;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quot <= w_q_nxt;
                            r_rem  <= w_r_nxt;
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
